hazard_dest_pipe: RTL and testbench

Destination-tracking pipeline for the 5-stage ARM core: it records each issued instruction's destination register and write-back enable as the instruction moves through EXE, MEM and WB. It supplies the Exe/Mem destination and write-enable inputs that the hazard detector compares against, and it applies the detector's stall decision by inserting bubbles. It sits beside the ID/EXE, EXE/MEM and MEM/WB pipeline registers, between the ID stage and the hazard detector.

---
 rtl/hazard_dest_pipe_if.sv | 46 ++++
 rtl/hazard_dest_pipe.sv | 114 +++++++++++
 tb/tb_hazard_dest_pipe.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_dest_pipe_if.sv
// Handshake bundle between the ID stage / hazard detector and hazard_dest_pipe.
// Counter signals exist only when HAZARD_STATS_EN is defined.
interface hazard_dest_pipe_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_wb_en;
  logic                  hazard_detected;
  logic                  flush;
  logic                  freeze;

  logic [REG_ADDR_W-1:0] exe_dest;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic                  exe_wb_en;
  logic                  mem_wb_en;
  logic                  wb_wb_en;
  logic                  id_stall;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0]      bubble_count;
  logic [CNT_W-1:0]      flush_count;
`endif

  if (REG_ADDR_W < 1 || CNT_W < 1) begin : g_param_chk
    $error("hazard_dest_pipe_if: REG_ADDR_W and CNT_W must be >= 1");
  end

  modport master (
    output id_valid, id_dest, id_wb_en, hazard_detected, flush, freeze,
    input  exe_dest, mem_dest, wb_dest, exe_wb_en, mem_wb_en, wb_wb_en, id_stall
`ifdef HAZARD_STATS_EN
    , input bubble_count, flush_count
`endif
  );

  modport slave (
    input  id_valid, id_dest, id_wb_en, hazard_detected, flush, freeze,
    output exe_dest, mem_dest, wb_dest, exe_wb_en, mem_wb_en, wb_wb_en, id_stall
`ifdef HAZARD_STATS_EN
    , output bubble_count, flush_count
`endif
  );
endinterface

// File: rtl/hazard_dest_pipe.sv
// Tracks {dest, wb_en} through EXE/MEM/WB and applies hazard stalls as bubbles.
// Optional bubble/flush statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_dest_pipe #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_dest_pipe_if.slave pif
);

  logic [REG_ADDR_W-1:0] exe_dest_q, exe_dest_d;
  logic [REG_ADDR_W-1:0] mem_dest_q, mem_dest_d;
  logic [REG_ADDR_W-1:0] wb_dest_q,  wb_dest_d;
  logic                  exe_wb_en_q, exe_wb_en_d;
  logic                  mem_wb_en_q, mem_wb_en_d;
  logic                  wb_wb_en_q,  wb_wb_en_d;

  logic advance;
  logic take_id;

  if (REG_ADDR_W < 1 || CNT_W < 1) begin : g_param_chk
    $error("hazard_dest_pipe: REG_ADDR_W and CNT_W must be >= 1");
  end

  // freeze beats flush beats hazard; only a clean cycle admits the ID instruction
  always_comb begin
    advance = ~pif.freeze;
    take_id = advance & ~pif.flush & ~pif.hazard_detected;

    exe_dest_d  = exe_dest_q;
    exe_wb_en_d = exe_wb_en_q;
    mem_dest_d  = mem_dest_q;
    mem_wb_en_d = mem_wb_en_q;
    wb_dest_d   = wb_dest_q;
    wb_wb_en_d  = wb_wb_en_q;

    if (advance) begin
      wb_dest_d   = mem_dest_q;
      wb_wb_en_d  = mem_wb_en_q;
      mem_dest_d  = exe_dest_q;
      mem_wb_en_d = exe_wb_en_q;
      if (take_id) begin
        exe_dest_d  = pif.id_dest;
        exe_wb_en_d = pif.id_wb_en & pif.id_valid;
      end else begin
        exe_dest_d  = '0;
        exe_wb_en_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_dest_q  <= '0;
      exe_wb_en_q <= 1'b0;
      mem_dest_q  <= '0;
      mem_wb_en_q <= 1'b0;
      wb_dest_q   <= '0;
      wb_wb_en_q  <= 1'b0;
    end else begin
      exe_dest_q  <= exe_dest_d;
      exe_wb_en_q <= exe_wb_en_d;
      mem_dest_q  <= mem_dest_d;
      mem_wb_en_q <= mem_wb_en_d;
      wb_dest_q   <= wb_dest_d;
      wb_wb_en_q  <= wb_wb_en_d;
    end
  end

  assign pif.exe_dest  = exe_dest_q;
  assign pif.exe_wb_en = exe_wb_en_q;
  assign pif.mem_dest  = mem_dest_q;
  assign pif.mem_wb_en = mem_wb_en_q;
  assign pif.wb_dest   = wb_dest_q;
  assign pif.wb_wb_en  = wb_wb_en_q;

  // a flushed instruction is being killed, so there is nothing to hold for it
  assign pif.id_stall = pif.freeze | (pif.hazard_detected & ~pif.flush);

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] bubble_count_q, bubble_count_d;
  logic [CNT_W-1:0] flush_count_q,  flush_count_d;
  logic             bubble_evt;
  logic             flush_evt;

  always_comb begin
    bubble_evt     = pif.hazard_detected & ~pif.flush & ~pif.freeze;
    flush_evt      = pif.flush & ~pif.freeze;
    bubble_count_d = bubble_count_q;
    flush_count_d  = flush_count_q;
    if (bubble_evt && (bubble_count_q != {CNT_W{1'b1}})) begin
      bubble_count_d = bubble_count_q + 1'b1;
    end
    if (flush_evt && (flush_count_q != {CNT_W{1'b1}})) begin
      flush_count_d = flush_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count_q <= '0;
      flush_count_q  <= '0;
    end else begin
      bubble_count_q <= bubble_count_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign pif.bubble_count = bubble_count_q;
  assign pif.flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_dest_pipe.sv
// Directed, table-driven bench for hazard_dest_pipe; stats checks run when HAZARD_STATS_EN is defined.
module tb_hazard_dest_pipe;

  localparam int RW = 5;
`ifdef HAZARD_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic clk;
  logic rst;

  hazard_dest_pipe_if #(.REG_ADDR_W(RW), .CNT_W(CW)) pif ();

  hazard_dest_pipe #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [RW-1:0] d;
    logic          w;
    logic          hz;
    logic          fl;
    logic          fz;
    logic          stall;
    logic [RW-1:0] ed;
    logic          ee;
    logic [RW-1:0] md;
    logic          me;
    logic [RW-1:0] wd;
    logic          we;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  int n_chk;
  int n_fail;

  function automatic vec_t mk(input int v, input int d, input int w, input int hz,
                              input int fl, input int fz, input int st,
                              input int ed, input int ee, input int md, input int me,
                              input int wd, input int we);
    vec_t r;
    r.v = 1'(v);  r.d = RW'(d);  r.w = 1'(w);
    r.hz = 1'(hz); r.fl = 1'(fl); r.fz = 1'(fz); r.stall = 1'(st);
    r.ed = RW'(ed); r.ee = 1'(ee);
    r.md = RW'(md); r.me = 1'(me);
    r.wd = RW'(wd); r.we = 1'(we);
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic drv(input int v, input int d, input int w, input int hz, input int fl, input int fz);
    pif.id_valid        = 1'(v);
    pif.id_dest         = RW'(d);
    pif.id_wb_en        = 1'(w);
    pif.hazard_detected = 1'(hz);
    pif.flush           = 1'(fl);
    pif.freeze          = 1'(fz);
  endtask

  task automatic chk_slots(input string nm, input int idx,
                           input int ed, input int ee, input int md, input int me,
                           input int wd, input int we);
    chk({nm, "_exe_dest"},  idx, 32'(pif.exe_dest),  32'(ed));
    chk({nm, "_exe_wb_en"}, idx, 32'(pif.exe_wb_en), 32'(ee));
    chk({nm, "_mem_dest"},  idx, 32'(pif.mem_dest),  32'(md));
    chk({nm, "_mem_wb_en"}, idx, 32'(pif.mem_wb_en), 32'(me));
    chk({nm, "_wb_dest"},   idx, 32'(pif.wb_dest),   32'(wd));
    chk({nm, "_wb_wb_en"},  idx, 32'(pif.wb_wb_en),  32'(we));
  endtask

  task automatic step(input int v, input int d, input int w, input int hz, input int fl, input int fz);
    @(negedge clk);
    drv(v, d, w, hz, fl, fz);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    //                 v  d  w hz fl fz st  ed ee md me wd we
    vecs[0]  = mk(1, 3, 1, 0, 0, 0, 0,   3, 1, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 3, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 1);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 5, 1, 0, 0, 0, 0,   5, 1, 0, 0, 0, 0);
    vecs[5]  = mk(1, 7, 1, 1, 0, 0, 1,   0, 0, 5, 1, 0, 0);
    vecs[6]  = mk(1, 7, 1, 1, 0, 0, 1,   0, 0, 0, 0, 5, 1);
    vecs[7]  = mk(1, 7, 1, 0, 0, 0, 0,   7, 1, 0, 0, 0, 0);
    vecs[8]  = mk(1, 3, 1, 0, 0, 0, 0,   3, 1, 7, 1, 0, 0);
    vecs[9]  = mk(1, 2, 1, 0, 0, 0, 0,   2, 1, 3, 1, 7, 1);
    vecs[10] = mk(1, 1, 1, 0, 0, 0, 0,   1, 1, 2, 1, 3, 1);
    vecs[11] = mk(1, 9, 1, 1, 0, 1, 1,   1, 1, 2, 1, 3, 1);
    vecs[12] = mk(1, 9, 1, 1, 0, 1, 1,   1, 1, 2, 1, 3, 1);
    vecs[13] = mk(1, 9, 1, 1, 0, 1, 1,   1, 1, 2, 1, 3, 1);
    vecs[14] = mk(1, 6, 1, 0, 0, 0, 0,   6, 1, 1, 1, 2, 1);
    vecs[15] = mk(1, 4, 1, 0, 0, 0, 0,   4, 1, 6, 1, 1, 1);
    vecs[16] = mk(1, 9, 1, 1, 1, 0, 0,   0, 0, 4, 1, 6, 1);
    vecs[17] = mk(0, 12, 1, 0, 0, 0, 0, 12, 0, 0, 0, 4, 1);
    vecs[18] = mk(1, 8, 1, 0, 1, 0, 0,   0, 0, 12, 0, 0, 0);
    vecs[19] = mk(1, 8, 1, 0, 1, 1, 1,   0, 0, 12, 0, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 12, 0);

    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    #12;
    chk_slots("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset_id_stall", 0, 32'(pif.id_stall), 32'd0);
`ifdef HAZARD_STATS_EN
    chk("reset_bubble_count", 0, 32'(pif.bubble_count), 32'd0);
    chk("reset_flush_count",  0, 32'(pif.flush_count),  32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drv(vecs[i].v, vecs[i].d, vecs[i].w, vecs[i].hz, vecs[i].fl, vecs[i].fz);
      #1;
      chk("id_stall", i, 32'(pif.id_stall), 32'(vecs[i].stall));
      @(posedge clk);
      #1;
      chk_slots("vec", i, vecs[i].ed, vecs[i].ee, vecs[i].md, vecs[i].me, vecs[i].wd, vecs[i].we);
    end

`ifdef HAZARD_STATS_EN
    // table so far: 2 hazard edges, 2 flush edges; frozen hazard/flush edges are not counted
    chk("bubble_after_table", 0, 32'(pif.bubble_count), 32'd2);
    chk("flush_after_table",  0, 32'(pif.flush_count),  32'd2);
    step(1, 7, 1, 1, 0, 0);
    chk("bubble_three", 0, 32'(pif.bubble_count), 32'd3);
    step(1, 7, 1, 1, 0, 0);
    step(1, 7, 1, 1, 0, 0);
    chk("bubble_saturate", 0, 32'(pif.bubble_count), 32'd3);
    step(1, 7, 1, 0, 1, 0);
    chk("flush_three", 0, 32'(pif.flush_count), 32'd3);
    step(1, 7, 1, 0, 1, 0);
    chk("flush_saturate", 0, 32'(pif.flush_count), 32'd3);
`endif

    step(1, 10, 1, 0, 0, 0);
    step(1, 11, 1, 0, 0, 0);
    step(1, 13, 1, 0, 0, 0);
    chk_slots("prefill", 0, 13, 1, 11, 1, 10, 1);

    // asynchronous reset between edges, with a hazard pending on the inputs
    @(negedge clk);
    drv(1, 14, 1, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_slots("async_rst", 0, 0, 0, 0, 0, 0, 0);
    chk("async_rst_id_stall", 0, 32'(pif.id_stall), 32'd1);
`ifdef HAZARD_STATS_EN
    chk("async_rst_bubble_count", 0, 32'(pif.bubble_count), 32'd0);
    chk("async_rst_flush_count",  0, 32'(pif.flush_count),  32'd0);
`endif
    #1;
    rst = 1'b0;
    drv(1, 15, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_slots("after_rst", 0, 15, 1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
